// File: rtl/rca_stream_adder_pkg.sv
// Shared definitions for the ripple-carry stream adder.
//   DEF_WIDTH / DEF_DEPTH : default operand width and FIFO depth
//   SUM_W, PTR_W          : derived sum width and FIFO pointer width
//   sum_t                 : one buffered result
//   fifo_state_t          : FIFO occupancy class (EMPTY / PARTIAL / FULL)
package rca_stream_adder_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned SUM_W     = DEF_WIDTH + 1;
  localparam int unsigned PTR_W     = $clog2(DEF_DEPTH);

  typedef logic [SUM_W-1:0] sum_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/rca_stream_adder_rca.sv
// Combinational ripple-carry adder core.
//   a, b : WIDTH-bit unsigned operands
//   y    : WIDTH+1-bit sum, carry-out in the MSB
module rca_stream_adder_rca #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   y
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign y = {c[WIDTH], s};

endmodule

// File: rtl/rca_stream_adder.sv
// Registered, flow-controlled wrapper around the ripple-carry adder core.
// Operand pairs arrive over a valid/ready handshake; each sum is buffered
// in a small FIFO, and a running total with sticky overflow and a
// saturating pair counter is maintained.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake, in_a/in_b operands
//   out_valid/out_ready  : result handshake, out_sum = FIFO head
//   acc_clear            : synchronous clear of the accumulator block
//   acc_total/acc_ovf    : running total and sticky wrap flag
//   pair_count           : accepted pairs, saturating at 255
module rca_stream_adder
  import rca_stream_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_sum,
  input  logic                 acc_clear,
  output logic [ACC_WIDTH-1:0] acc_total,
  output logic                 acc_ovf,
  output logic [7:0]           pair_count
);

  localparam int unsigned SW  = WIDTH + 1;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned AW1 = ACC_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [SW-1:0] sum;
  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] last_pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  fifo_state_t   state;
  logic          push;
  logic          pop;

  rca_stream_adder_rca #(.WIDTH(WIDTH)) u_rca (
    .a (in_a),
    .b (in_b),
    .y (sum)
  );

  // Occupancy class derived from the registered count.
  always_comb begin
    state = PARTIAL;
    if (count == '0)            state = EMPTY;
    else if (count == FULL_CNT) state = FULL;
  end

  // Handshake and head outputs depend only on registered state.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    // An empty FIFO shows the most recently popped value, not a stale slot.
    out_sum   = out_valid ? mem[rd_ptr] : last_pop;
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sum;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_pop <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear applies before the add, so clear+push leaves just this sum.
  logic [ACC_WIDTH-1:0] acc_base;
  logic                 ovf_base;
  logic [7:0]           cnt_base;
  logic [AW1-1:0]       acc_next;

  always_comb begin
    acc_base = acc_clear ? '0 : acc_total;
    ovf_base = acc_clear ? 1'b0 : acc_ovf;
    cnt_base = acc_clear ? '0 : pair_count;
    acc_next = {1'b0, acc_base} + AW1'(sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_total  <= '0;
      acc_ovf    <= 1'b0;
      pair_count <= '0;
    end else if (push) begin
      acc_total  <= acc_next[ACC_WIDTH-1:0];
      acc_ovf    <= ovf_base | acc_next[ACC_WIDTH];
      pair_count <= (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
    end else if (acc_clear) begin
      acc_total  <= '0;
      acc_ovf    <= 1'b0;
      pair_count <= '0;
    end
  end

endmodule
